// File: rtl/rram_instr_pkg.sv
// Shared opcodes, register offsets and issue-FSM state type for the RRAM instruction issuer.
// Also holds the host-command encoder used on the Wishbone write path.
package rram_instr_pkg;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_READ   = 4'h2;
  localparam logic [3:0] OP_MAC    = 4'h3;
  localparam logic [3:0] OP_CONF_T = 4'h4;
  localparam logic [3:0] OP_CONF_V = 4'h5;
  // Not a decoder opcode, so the decoder treats it as an idle slot
  localparam logic [3:0] NOP       = 4'hF;

  localparam logic [31:0] NOP_WORD = {NOP, 28'b0};

  localparam logic [7:0] OFF_WRITE  = 8'h00;
  localparam logic [7:0] OFF_READ   = 8'h04;
  localparam logic [7:0] OFF_MAC    = 8'h08;
  localparam logic [7:0] OFF_CONF_T = 8'h0C;
  localparam logic [7:0] OFF_CONF_V = 8'h10;
  localparam logic [7:0] OFF_RAW    = 8'h14;
  localparam logic [7:0] OFF_STATUS = 8'h18;
  localparam logic [7:0] OFF_CTRL   = 8'h1C;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } issue_state_e;

  function automatic logic is_cmd_offset(input logic [7:0] off);
    return off inside {OFF_WRITE, OFF_READ, OFF_MAC, OFF_CONF_T, OFF_CONF_V, OFF_RAW};
  endfunction

  function automatic logic [31:0] encode_cmd(input logic [7:0] off, input logic [31:0] dat);
    logic [31:0] word;
    word = '0;
    case (off)
      OFF_WRITE:  word = {OP_WRITE, 20'b0, dat[7:4], dat[3:0]};
      OFF_READ:   word = {OP_READ, 20'b0, dat[7:0]};
      OFF_MAC:    word = {OP_MAC, 12'b0, dat[15:0]};
      OFF_CONF_T: word = {OP_CONF_T, 18'b0, dat[9:0]};
      OFF_CONF_V: word = {OP_CONF_V, 24'b0, dat[3:0]};
      OFF_RAW:    word = dat;
      default:    word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/rram_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush, full/empty flags and fill count.
// Depth must be a power of two so the pointers wrap naturally.
module rram_cmd_fifo #(
  parameter int unsigned Depth  = 4,
  parameter int unsigned Width  = 32,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned CountW = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [Width-1:0]  data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CountW-1:0] count_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == CountW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted then
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CountW'(1);
        2'b01:   count_d = count_q - CountW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rram_instr_issuer.sv
// Wishbone command front end: encodes host commands, queues them and issues them with NOP gaps.
// Optional drain-complete interrupt is built only when RRAM_ISSUER_IRQ_EN is defined.
module rram_instr_issuer
  import rram_instr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ISSUE_GAP  = 2,
  parameter int unsigned MAC_GAP    = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        busy,
  output logic        irq_done
);

  localparam int unsigned GapMax = (ISSUE_GAP > MAC_GAP) ? ISSUE_GAP : MAC_GAP;
  localparam int unsigned CntW   = $clog2(GapMax + 2);
  localparam int unsigned FifoCw = $clog2(FIFO_DEPTH) + 1;
  // The IDLE cycle before the next pop is the last NOP slot, so GAP lasts one cycle less
  localparam logic [CntW-1:0] IssueLoad = CntW'((ISSUE_GAP > 1) ? ISSUE_GAP - 1 : 0);
  localparam logic [CntW-1:0] MacLoad   = CntW'((MAC_GAP > 1) ? MAC_GAP - 1 : 0);

  issue_state_e      state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              ovf_q, ovf_d;

  logic [7:0]        off;
  logic              hit, req, wr, push, ctrl_wr, flush, ovf_clr, pop;
  logic [31:0]       status;
  logic [31:0]       fifo_data;
  logic              fifo_full, fifo_empty;
  logic [FifoCw-1:0] fifo_count;
  logic              unused_sel;

  assign unused_sel = ^wbs_sel_i;

  assign off     = wbs_adr_i[7:0];
  assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req     = wbs_cyc_i && wbs_stb_i && !ack_q && hit;
  // Writes take effect on the edge that closes the ack cycle
  assign wr      = ack_q && wbs_cyc_i && wbs_stb_i && wbs_we_i;
  assign push    = wr && is_cmd_offset(off);
  assign ctrl_wr = wr && (off == OFF_CTRL);
  assign flush   = ctrl_wr && wbs_dat_i[1];
  assign ovf_clr = ctrl_wr && wbs_dat_i[0];

  always_comb begin
    status       = '0;
    status[7:0]  = 8'(fifo_count);
    status[8]    = fifo_full;
    status[9]    = fifo_empty;
    status[10]   = busy;
    status[11]   = ovf_q;
  end

  rram_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (encode_cmd(off, wbs_dat_i)),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    ack_d = req;
    dat_d = '0;
    if (req && !wbs_we_i && (off == OFF_STATUS)) dat_d = status;
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A flush landing on the same edge wins over the pop
        if (!fifo_empty && !flush) begin
          pop     = 1'b1;
          word_d  = fifo_data;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = (word_q[31:28] == OP_MAC) ? MacLoad : IssueLoad;
        state_d = StGap;
      end
      StGap: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      word_q  <= NOP_WORD;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign instr_valid = (state_q == StIssue);
  assign instruction = (state_q == StIssue) ? word_q : NOP_WORD;
  assign busy        = (state_q != StIdle) || !fifo_empty;

`ifdef RRAM_ISSUER_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (state_q == StGap) && (state_d == StIdle) && fifo_empty && !push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_done = irq_q;
`else
  assign irq_done = 1'b0;
`endif

endmodule

// File: tb/tb_rram_instr_issuer.sv
// Directed bench for rram_instr_issuer: encoding table, issue spacing, overflow, flush, reset, irq.
module tb_rram_instr_issuer;

  localparam logic [31:0] Base    = 32'h3000_0000;
  localparam logic [31:0] NopWord = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] instruction;
  logic        instr_valid, busy, irq_done;

  always #5 clk = ~clk;

  rram_instr_issuer dut (
    .clk         (clk),
    .rst         (rst),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .busy        (busy),
    .irq_done    (irq_done)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc_n    = 0;
  logic [31:0] log_word[$];
  int unsigned log_cyc[$];
  int          irq_n    = 0;
  int unsigned irq_cyc  = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (instr_valid) begin
      log_word.push_back(instruction);
      log_cyc.push_back(cyc_n);
    end
    if (irq_done) begin
      irq_n++;
      irq_cyc = cyc_n;
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts 1ns after a rising edge; returns 1ns after the edge that closes the ack cycle
  task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] dat,
                         output logic [31:0] rdata);
    int n;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = Base | {24'b0, off};
    wbs_dat_i = dat;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wbs_ack_o && n < 20);
    check("wb_ack", 32'(wbs_ack_o), 32'd1);
    rdata = wbs_dat_o;
    @(posedge clk);
    #1;
    check("wb_ack_one_cycle", 32'(wbs_ack_o), 32'd0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  off;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    int          b;
    int          ib;

    vecs[0]  = '{8'h00, 32'h0000_0035, 32'h1000_0035};
    vecs[1]  = '{8'h00, 32'hFFFF_FFAB, 32'h1000_00AB};
    vecs[2]  = '{8'h04, 32'h0000_0012, 32'h2000_0012};
    vecs[3]  = '{8'h04, 32'hABCD_EF99, 32'h2000_0099};
    vecs[4]  = '{8'h08, 32'h0000_0F3C, 32'h3000_0F3C};
    vecs[5]  = '{8'h08, 32'hFFFF_1234, 32'h3000_1234};
    vecs[6]  = '{8'h0C, 32'h0000_03FF, 32'h4000_03FF};
    vecs[7]  = '{8'h0C, 32'hFFFF_FC01, 32'h4000_0001};
    vecs[8]  = '{8'h10, 32'h0000_0007, 32'h5000_0007};
    vecs[9]  = '{8'h10, 32'hFFFF_FFF9, 32'h5000_0009};
    vecs[10] = '{8'h14, 32'h1234_5678, 32'h1234_5678};
    vecs[11] = '{8'h14, 32'h3000_00AA, 32'h3000_00AA};

    rst       = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_instruction", instruction, NopWord);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq_done), 32'd0);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    rst = 1'b1;

    wb_xfer(1'b0, 8'h18, 32'd0, rd);
    check("status_after_reset", rd, 32'h0000_0200);
    wb_xfer(1'b0, 8'h00, 32'd0, rd);
    check("read_cmd_offset", rd, 32'd0);
    wb_xfer(1'b0, 8'h1C, 32'd0, rd);
    check("read_ctrl", rd, 32'd0);
    wb_xfer(1'b0, 8'h40, 32'd0, rd);
    check("read_unmapped", rd, 32'd0);
    wb_xfer(1'b1, 8'h40, 32'h1234_5678, rd);
    wb_xfer(1'b0, 8'h18, 32'd0, rd);
    check("unmapped_write_ignored", rd, 32'h0000_0200);

    // Encoding table: one push, issue exactly two cycles after the ack cycle
    for (int i = 0; i < 12; i++) begin
      wb_xfer(1'b1, vecs[i].off, vecs[i].dat, rd);
      check($sformatf("vec%0d_pre_valid", i), 32'(instr_valid), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'd1);
      check($sformatf("vec%0d_word", i), instruction, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_post_valid", i), 32'(instr_valid), 32'd0);
      check($sformatf("vec%0d_post_nop", i), instruction, NopWord);
      wait_idle();
    end

    // MAC then READ: pulses 1 + MAC_GAP apart
    b = log_word.size();
    wb_xfer(1'b1, 8'h08, 32'h0000_0F3C, rd);
    wb_xfer(1'b1, 8'h04, 32'h0000_0012, rd);
    wait_idle();
    check("mac_read_count", 32'(log_word.size() - b), 32'd2);
    if (log_word.size() >= b + 2) begin
      check("mac_word", log_word[b], 32'h3000_0F3C);
      check("read_word", log_word[b+1], 32'h2000_0012);
      check("mac_spacing", 32'(log_cyc[b+1] - log_cyc[b]), 32'd5);
    end

    // WRITE then WRITE: pulses 1 + ISSUE_GAP apart, one drain interrupt at the end
    b  = log_word.size();
    ib = irq_n;
    wb_xfer(1'b1, 8'h00, 32'h0000_0011, rd);
    wb_xfer(1'b1, 8'h00, 32'h0000_0022, rd);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("ww_count", 32'(log_word.size() - b), 32'd2);
    if (log_word.size() >= b + 2) begin
      check("ww_spacing", 32'(log_cyc[b+1] - log_cyc[b]), 32'd3);
`ifdef RRAM_ISSUER_IRQ_EN
      check("irq_count", 32'(irq_n - ib), 32'd1);
      check("irq_timing", 32'(irq_cyc - log_cyc[b+1]), 32'd2);
`else
      check("irq_count", 32'(irq_n - ib), 32'd0);
`endif
    end

    // Overflow: MACs every two cycles outpace one pop per five cycles
    b = log_word.size();
    for (int i = 0; i < 7; i++) wb_xfer(1'b1, 8'h08, 32'h0000_0100 + 32'(i), rd);
    repeat (2) @(posedge clk);
    #1;
    wb_xfer(1'b1, 8'h08, 32'h0000_0107, rd);   // lands with a pop while full: accepted
    wb_xfer(1'b0, 8'h18, 32'd0, rd);
    check("status_full_no_ovf", rd, 32'h0000_0504);
    wb_xfer(1'b1, 8'h08, 32'h0000_0108, rd);   // full, no pop: dropped
    wb_xfer(1'b0, 8'h18, 32'd0, rd);
    check("status_full_ovf", rd, 32'h0000_0D04);
    wb_xfer(1'b1, 8'h1C, 32'h0000_0001, rd);
    wb_xfer(1'b0, 8'h18, 32'd0, rd);
    check("ovf_cleared", 32'(rd[11]), 32'd0);
    wait_idle();
    check("ovf_issue_count", 32'(log_word.size() - b), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (log_word.size() > b + i)
        check($sformatf("ovf_word%0d", i), log_word[b+i], 32'h3000_0100 + 32'(i));
    end

    // Flush lands on the pop edge with three entries queued
    b = log_word.size();
    for (int i = 0; i < 5; i++) wb_xfer(1'b1, 8'h08, 32'h0000_0200 + 32'(i), rd);
    @(posedge clk);
    #1;
    wb_xfer(1'b1, 8'h1C, 32'h0000_0002, rd);
    wb_xfer(1'b0, 8'h18, 32'd0, rd);
    check("flush_status", rd, 32'h0000_0200);
    repeat (20) @(posedge clk);
    #1;
    check("flush_issue_count", 32'(log_word.size() - b), 32'd2);
    if (log_word.size() >= b + 2) begin
      check("flush_word0", log_word[b], 32'h3000_0200);
      check("flush_word1", log_word[b+1], 32'h3000_0201);
    end

    // Reset during ISSUE with one entry still queued
    b = log_word.size();
    wb_xfer(1'b1, 8'h00, 32'h0000_00A1, rd);
    wb_xfer(1'b1, 8'h00, 32'h0000_00B2, rd);
    wb_xfer(1'b1, 8'h00, 32'h0000_00C3, rd);
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
    check("pre_rst_word", instruction, 32'h1000_00B2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_instruction", instruction, NopWord);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b1;
    wb_xfer(1'b0, 8'h18, 32'd0, rd);
    check("post_rst_status", rd, 32'h0000_0200);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_issue_count", 32'(log_word.size() - b), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
